// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch front end: FSM states, reset PC, PC step
// and instruction width.
package cpu_defs;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int          INSN_W       = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP  = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_adder.sv
// 32-bit modulo pc + PC_STEP; feeds both the link-register output and the PC update.
module pc_adder import cpu_defs::*; #(
  parameter logic [31:0] PC_STEP = DEF_PC_STEP
)(
  input  logic [31:0] pc,
  output logic [31:0] sum
);

  assign sum = pc + PC_STEP;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC/IR owner with a req/ack memory handshake.
// Optional build macro FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets.
module fetch_unit import cpu_defs::*; #(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [31:0] PC_STEP     = DEF_PC_STEP,
  parameter int          ACK_TIMEOUT = 15
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_go,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic [INSN_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [INSN_W-1:0] ir,
  output logic              ir_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              busy,
  output logic              fetch_err
);

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [7:0]        cnt;
  logic              pend;
  logic [31:0]       pend_pc;
  logic [INSN_W-1:0] word;
  logic [31:0]       pc_next;

  logic              start, ack_take, timeout;
  logic              redir_ok, redir_bad;
  logic [31:0]       redir_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);
  assign redir_ok  = redirect && !redir_bad;
  assign redir_tgt = redirect_pc;
`else
  assign redir_bad = 1'b0;
  assign redir_ok  = redirect;
  assign redir_tgt = align_pc(redirect_pc);
`endif

  pc_adder #(.PC_STEP(PC_STEP)) u_add (.pc(pc), .sum(pc_next));

  assign pc_plus4 = pc_next;
  assign mem_addr = pc;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ack_take  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        // A trapped redirect suppresses the fetch requested in the same cycle.
        if (fetch_go && !redir_bad) begin
          start     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          ack_take  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      ir_valid  <= 1'b0;
      mem_req   <= 1'b0;
      fetch_err <= 1'b0;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_pc   <= '0;
      word      <= '0;
    end else begin
      ir_valid  <= 1'b0;
      fetch_err <= redir_bad | timeout;
      case (state)
        IDLE: begin
          if (redir_ok) pc <= redir_tgt;
          if (start) begin
            mem_req <= 1'b1;
            cnt     <= '0;
          end
        end
        WAIT: begin
          if (redir_ok) begin
            pend    <= 1'b1;
            pend_pc <= redir_tgt;
          end
          if (ack_take) begin
            word    <= mem_rdata;
            mem_req <= 1'b0;
          end else if (timeout) begin
            // Abandoned fetch: PC stays put and any queued redirect is dropped.
            mem_req <= 1'b0;
            pend    <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          pend <= 1'b0;
          // A redirect arriving in DONE is as good as one queued earlier.
          if (redir_ok)  pc <= redir_tgt;
          else if (pend) pc <= pend_pc;
          else begin
            ir       <= word;
            ir_valid <= 1'b1;
            pc       <= pc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a cycle-count based
// transaction model of the fetch protocol.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_go, redirect, mem_ack;
  logic [31:0] redirect_pc, mem_rdata;
  logic        mem_req, ir_valid, busy, fetch_err;
  logic [31:0] mem_addr, ir, pc, pc_plus4;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] m_pc, m_ir;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .PC_STEP(32'd4), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .fetch_go(fetch_go), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir(ir), .ir_valid(ir_valid),
    .pc(pc), .pc_plus4(pc_plus4), .busy(busy), .fetch_err(fetch_err)
  );

  task automatic idle_inputs();
    fetch_go    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = $urandom;
    mem_ack     = 1'b0;
    mem_rdata   = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    vectors++; if (pc !== 32'h0)       begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    vectors++; if (ir !== 32'h0)       begin errors++; $display("FAIL reset_ir got %h want 0", ir); end
    vectors++; if ({mem_req, ir_valid, fetch_err, busy} !== 4'b0)
      begin errors++; $display("FAIL reset_flags got %b want 0000", {mem_req, ir_valid, fetch_err, busy}); end
    vectors++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h want 4", pc_plus4); end
    rst  = 1'b0;
    m_pc = 32'h0;
    m_ir = 32'h0;
  endtask

  // d = WAIT cycles without ack before the ack cycle; rk >= 0 places a redirect
  // to tgt in cycle rk+1 (WAIT or DONE); same = redirect to gtgt alongside fetch_go.
  task automatic run_fetch(input int d, input int rk, input logic [31:0] tgt,
                           input logic [31:0] wd, input logic same, input logic [31:0] gtgt);
    logic [31:0] pc0, pcf, exp_pc;
    logic        disc;
    pc0  = same ? {gtgt[31:2], 2'b00} : m_pc;
    disc = (rk >= 0);
    pcf  = disc ? {tgt[31:2], 2'b00} : pc0 + 32'd4;
    for (int c = 0; c <= d + 4; c++) begin
      @(negedge clk);
      exp_pc = (c == 0) ? m_pc : ((c <= d + 2) ? pc0 : pcf);
      vectors++; if (pc !== exp_pc || mem_addr !== exp_pc)
        begin errors++; $display("FAIL fetch_pc c=%0d got pc=%h addr=%h want %h", c, pc, mem_addr, exp_pc); end
      vectors++; if (mem_req !== (c >= 1 && c <= d + 1))
        begin errors++; $display("FAIL fetch_req c=%0d got %b want %b", c, mem_req, (c >= 1 && c <= d + 1)); end
      vectors++; if (busy !== (c >= 1 && c <= d + 2))
        begin errors++; $display("FAIL fetch_busy c=%0d got %b want %b", c, busy, (c >= 1 && c <= d + 2)); end
      vectors++; if (ir_valid !== (c == d + 3 && !disc) || fetch_err !== 1'b0)
        begin errors++; $display("FAIL fetch_pulses c=%0d got iv=%b err=%b want iv=%b err=0", c, ir_valid, fetch_err, (c == d + 3 && !disc)); end
      if (c == d + 3) begin
        vectors++; if (ir !== (disc ? m_ir : wd))
          begin errors++; $display("FAIL fetch_ir got %h want %h", ir, disc ? m_ir : wd); end
        vectors++; if (pc_plus4 !== pcf + 32'd4)
          begin errors++; $display("FAIL fetch_pc_plus4 got %h want %h", pc_plus4, pcf + 32'd4); end
      end
      idle_inputs();
      if (c == 0) begin
        fetch_go = 1'b1;
        if (same) begin redirect = 1'b1; redirect_pc = gtgt; end
        mem_ack = $urandom_range(0, 1);
      end else if (c <= d + 2) begin
        fetch_go = $urandom_range(0, 1);
        if (c <= d + 1) begin
          mem_ack = (c == d + 1);
          if (mem_ack) mem_rdata = wd;
        end else begin
          mem_ack = $urandom_range(0, 1);
        end
        if (disc && c == 1 && rk != 0) begin
          redirect = 1'b1; redirect_pc = {$urandom_range(0, 32'h3FFF), 2'b00};
        end
        if (disc && c == rk + 1) begin redirect = 1'b1; redirect_pc = tgt; end
      end
    end
    m_pc = pcf;
    if (!disc) m_ir = wd;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    @(negedge clk);
    idle_inputs();
    redirect = 1'b1; redirect_pc = tgt;
    @(negedge clk);
    m_pc = {tgt[31:2], 2'b00};
    vectors++; if (pc !== m_pc || fetch_err !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL idle_redirect got pc=%h err=%b busy=%b want pc=%h err=0 busy=0", pc, fetch_err, busy, m_pc); end
    idle_inputs();
  endtask

  task automatic test_zero_wait();
    run_fetch(0, -1, 32'h0, 32'h2002_0005, 1'b0, 32'h0);
    vectors++; if (pc !== 32'h4 || pc_plus4 !== 32'h8)
      begin errors++; $display("FAIL zero_wait_pc got %h/%h want 4/8", pc, pc_plus4); end
  endtask

  task automatic test_slow_mem();
    run_fetch(4, -1, 32'h0, $urandom, 1'b0, 32'h0);
  endtask

  task automatic test_redirect_wait();
    run_fetch(3, 1, 32'h0000_0040, $urandom, 1'b0, 32'h0);
    run_fetch(0, -1, 32'h0, $urandom, 1'b0, 32'h0);
  endtask

  task automatic test_go_and_redirect();
    run_fetch(1, -1, 32'h0, $urandom, 1'b1, 32'h0000_0100);
    vectors++; if (pc !== 32'h104) begin errors++; $display("FAIL go_redirect_pc got %h want 104", pc); end
  endtask

  task automatic test_timeout();
    logic [31:0] pc0;
    pc0 = m_pc;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      vectors++; if (mem_req !== (c >= 1 && c <= 15) || busy !== (c >= 1 && c <= 15))
        begin errors++; $display("FAIL timeout_req c=%0d got req=%b busy=%b", c, mem_req, busy); end
      vectors++; if (fetch_err !== (c == 16) || pc !== pc0 || ir !== m_ir)
        begin errors++; $display("FAIL timeout_err c=%0d got err=%b pc=%h ir=%h want pc=%h ir=%h", c, fetch_err, pc, ir, pc0, m_ir); end
      idle_inputs();
      if (c == 0) fetch_go = 1'b1;
      else if (c <= 15) fetch_go = $urandom_range(0, 1);
    end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    idle_inputs();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_go = 1'b1;
    @(negedge clk);
    vectors++; if (fetch_err !== 1'b1 || pc !== m_pc || mem_req !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL misalign_trap got err=%b pc=%h req=%b busy=%b want 1/%h/0/0", fetch_err, pc, mem_req, busy, m_pc); end
    idle_inputs();
    @(negedge clk);
    vectors++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL misalign_pulse got %b want 0", fetch_err); end
`else
    @(negedge clk);
    vectors++; if (fetch_err !== 1'b0 || pc !== 32'h100)
      begin errors++; $display("FAIL misalign_align got err=%b pc=%h want 0/100", fetch_err, pc); end
    m_pc = 32'h100;
    idle_inputs();
`endif
  endtask

  task automatic test_reset_mid();
    do_redirect(32'h0000_0020);
    @(negedge clk);
    fetch_go = 1'b1;
    @(negedge clk);
    idle_inputs();
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h20)
      begin errors++; $display("FAIL mid_wait got req=%b addr=%h want 1/20", mem_req, mem_addr); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0 || pc !== 32'h0 || busy !== 1'b0 || ir !== 32'h0)
      begin errors++; $display("FAIL async_reset got req=%b pc=%h busy=%b ir=%h", mem_req, pc, busy, ir); end
    @(negedge clk);
    rst  = 1'b0;
    m_pc = 32'h0;
    m_ir = 32'h0;
    do_redirect(32'hFFFF_FFFC);
    run_fetch(1, -1, 32'h0, $urandom, 1'b0, 32'h0);
    vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      int d, rk;
      d  = $urandom_range(0, 8);
      rk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, d + 1) : -1;
      run_fetch(d, rk, {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom,
                ($urandom_range(0, 3) == 0), {$urandom_range(0, 32'h3FFF), 2'b00});
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_slow_mem();
    test_redirect_wait();
    test_go_and_redirect();
    test_timeout();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
